i2s_pcm_tx: RTL and testbench

//  Read side of the DDFS PCM sample FIFO. Pops one 16-bit signed PCM sample per audio frame from a

---
 rtl/i2s_pcm_tx.sv | 78 +++++++
 tb/tb_i2s_pcm_tx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_pcm_tx.sv
// i2s_pcm_tx: drains a show-ahead PCM FIFO one sample per frame onto a Philips I2S master stream
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   en                    run the serializer; low parks all outputs and restarts the frame
//   fifo_empty            FIFO head invalid
//   fifo_rd_data          show-ahead FIFO head
//   fifo_rd_en            1-clk pop, combinational on the fetch cycle only
//   underflow             1-clk pulse when a sample was due and the FIFO was empty
//   i2s_bclk, i2s_lrclk   bit clock and word select (0 = left)
//   i2s_sdata             serial data, MSB first, changes with the bclk falling edge
module i2s_pcm_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  underflow,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata
);
  localparam int FW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(FW);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] sample_reg;
  logic [FW-1:0] shift_reg;
  logic tick, fall, fetch;
  always_comb begin
    tick = div_cnt == CW'(CLK_DIV - 1);
    fall = state == RUN && en && tick && i2s_bclk;
    bit_nxt = bit_cnt == BW'(FW - 1) ? '0 : bit_cnt + 1'b1;
    fetch = fall && bit_cnt == BW'(FW - 1);
  end
  assign fifo_rd_en = fetch && !fifo_empty;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= BW'(FW - 1);
      sample_reg <= '0;
      shift_reg <= '0;
      underflow <= 1'b0;
      i2s_bclk <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (state == IDLE || !en) begin
      // entering or leaving RUN: counters and outputs sit at reset values, sample_reg is kept
      state <= en ? RUN : IDLE;
      div_cnt <= '0;
      bit_cnt <= BW'(FW - 1);
      shift_reg <= '0;
      underflow <= 1'b0;
      i2s_bclk <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      underflow <= fetch && fifo_empty;
      if (tick) i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        i2s_lrclk <= bit_nxt >= BW'(DATA_WIDTH);
        // the word loaded at b=1 drives its MSB immediately, giving the one-bit I2S delay
        shift_reg <= bit_nxt == BW'(1) ? {sample_reg, sample_reg} : shift_reg << 1;
        i2s_sdata <= bit_nxt == BW'(1) ? sample_reg[DATA_WIDTH-1] : shift_reg[FW-2];
        if (fetch) sample_reg <= fifo_empty ? '0 : fifo_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_i2s_pcm_tx.sv
// tb_i2s_pcm_tx: randomized bench for i2s_pcm_tx against a frame-level I2S reference model
module tb_i2s_pcm_tx;
  localparam int DW = 16;
  localparam int CLK_DIV = 4;
  localparam int FW = 2 * DW;
  localparam int FRAME_CLKS = FW * 2 * CLK_DIV;
  logic clk, reset_n, en, fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic fifo_rd_en, underflow, i2s_bclk, i2s_lrclk, i2s_sdata;
  i2s_pcm_tx #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .underflow(underflow), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  logic [FW-1:0] wq[$];
  logic [FW-1:0] wacc;
  logic [DW-1:0] cur_s, prev_s, prv_data;
  logic prv_bclk, prv_lr, prv_sd, prv_rd, prv_empty, mon;
  int cyc = 0, k = -1, last_rise = -1, last_pop = -1, dut_pops = 0, dut_unf = 0;
  task automatic fifo_update();
    fifo_empty = q.size() == 0;
    fifo_rd_data = fifo_empty ? DW'($urandom) : q[0];
  endtask
  task automatic reset_mon();
    k = -1; last_rise = -1; last_pop = -1; wq.delete(); prev_s = '0; cur_s = '0; wacc = '0;
  endtask
  task automatic monitor();
    logic fell, rose, exp_sd;
    int b, f;
    fell = prv_bclk && !i2s_bclk;
    rose = !prv_bclk && i2s_bclk;
    checks++;
    if (!fell && (i2s_lrclk !== prv_lr || i2s_sdata !== prv_sd)) begin
      errors++;
      $display("FAIL edge_timing cyc=%0d lrclk %b->%b sdata %b->%b without bclk fall", cyc, prv_lr, i2s_lrclk, prv_sd, i2s_sdata);
    end
    checks++;
    if ((fifo_rd_en && underflow) !== 1'b0) begin
      errors++;
      $display("FAIL pop_underflow_excl cyc=%0d rd_en=%b underflow=%b required not both 1", cyc, fifo_rd_en, underflow);
    end
    if (rose) begin
      if (last_rise >= 0) begin
        checks++;
        if (cyc - last_rise != 2 * CLK_DIV) begin
          errors++;
          $display("FAIL bclk_period cyc=%0d got %0d clks required %0d", cyc, cyc - last_rise, 2 * CLK_DIV);
        end
      end
      last_rise = cyc;
    end
    checks++;
    if (prv_rd && !(fell && (k + 1) % FW == 0)) begin
      errors++;
      $display("FAIL pop_position cyc=%0d pop not followed by fall into b=0 (k=%0d)", cyc, k);
    end
    if (fell) begin
      k++;
      b = k % FW;
      f = k / FW;
      if (b == 0) begin
        if (f >= 1) wq.push_back({wacc[FW-2:0], i2s_sdata});
        checks++;
        if (prv_rd !== !prv_empty) begin
          errors++;
          $display("FAIL fetch_pop frame=%0d rd_en=%b required %b", f, prv_rd, !prv_empty);
        end
        checks++;
        if (underflow !== prv_empty) begin
          errors++;
          $display("FAIL fetch_underflow frame=%0d underflow=%b required %b", f, underflow, prv_empty);
        end
        if (!prv_empty) begin
          if (last_pop >= 0) begin
            checks++;
            if (cyc - last_pop != FRAME_CLKS) begin
              errors++;
              $display("FAIL pop_spacing got %0d clks required %0d", cyc - last_pop, FRAME_CLKS);
            end
          end
          last_pop = cyc;
        end else last_pop = -1;
        prev_s = cur_s;
        cur_s = prv_empty ? '0 : prv_data;
      end else wacc = {wacc[FW-2:0], i2s_sdata};
      exp_sd = b == 0 ? (f == 0 ? 1'b0 : prev_s[0]) : (b <= DW ? cur_s[DW-b] : cur_s[FW-b]);
      checks++;
      if (i2s_sdata !== exp_sd) begin
        errors++;
        $display("FAIL sdata frame=%0d b=%0d got %b required %b", f, b, i2s_sdata, exp_sd);
      end
      checks++;
      if (i2s_lrclk !== (b >= DW)) begin
        errors++;
        $display("FAIL lrclk frame=%0d b=%0d got %b required %b", f, b, i2s_lrclk, b >= DW);
      end
    end else begin
      checks++;
      if (underflow !== 1'b0) begin
        errors++;
        $display("FAIL underflow_stray cyc=%0d got %b required 0", cyc, underflow);
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (fifo_rd_en) dut_pops++;
    if (underflow) dut_unf++;
    if (mon && en) monitor();
    prv_bclk = i2s_bclk; prv_lr = i2s_lrclk; prv_sd = i2s_sdata;
    prv_rd = fifo_rd_en; prv_empty = fifo_empty; prv_data = fifo_rd_data;
    @(posedge clk);
    #1;
    if (prv_rd && q.size() > 0) void'(q.pop_front());
    fifo_update();
  endtask
  task automatic restart();
    en = 1'b0;
    step();
    step();
    reset_mon();
    mon = 1'b1;
    en = 1'b1;
  endtask
  task automatic wait_words(input int n, input string name);
    for (int i = 0; i < 6000 && wq.size() < n; i++) step();
    checks++;
    if (wq.size() < n) begin
      errors++;
      $display("FAIL %s_timeout words got %0d required %0d", name, wq.size(), n);
    end
  endtask
  task automatic wait_k(input int n, input string name);
    for (int i = 0; i < 2000 && k < n; i++) step();
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL %s_timeout k got %0d required %0d", name, k, n);
    end
  endtask
  task automatic test_reset();
    int n;
    logic [DW-1:0] s;
    @(negedge clk);
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, underflow, fifo_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 00000", {i2s_bclk, i2s_lrclk, i2s_sdata, underflow, fifo_rd_en});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(DW'($urandom));
    fifo_update();
    restart();
    repeat (300) step();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, underflow, fifo_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got %b required 00000", {i2s_bclk, i2s_lrclk, i2s_sdata, underflow, fifo_rd_en});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    q.delete();
    s = DW'($urandom);
    q.push_back(s);
    q.push_back(DW'($urandom));
    fifo_update();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (i2s_bclk) break;
    end
    checks++;
    if (n != CLK_DIV + 1) begin
      errors++;
      $display("FAIL first_rise got %0d edges after release required %0d", n, CLK_DIV + 1);
    end
    reset_mon();
    prv_bclk = i2s_bclk; prv_lr = i2s_lrclk; prv_sd = i2s_sdata;
    prv_rd = 1'b0; prv_empty = fifo_empty; prv_data = fifo_rd_data;
    wait_words(1, "reset_restart");
    checks++;
    if (wq.size() < 1 || wq[0] !== {s, s}) begin
      errors++;
      $display("FAIL reset_restart_word got %h required %h", wq.size() ? wq[0] : '0, {s, s});
    end
  endtask
  task automatic test_pattern();
    q.delete();
    q.push_back(16'hA5C3);
    q.push_back(DW'($urandom));
    fifo_update();
    restart();
    wait_words(1, "pattern");
    checks++;
    if (wq.size() < 1 || wq[0] !== 32'hA5C3A5C3) begin
      errors++;
      $display("FAIL pattern_word got %h required a5c3a5c3", wq.size() ? wq[0] : '0);
    end
  endtask
  task automatic test_back_to_back();
    q.delete();
    q.push_back(16'h8000);
    q.push_back(16'h7FFF);
    q.push_back(DW'($urandom));
    fifo_update();
    restart();
    wait_words(2, "b2b");
    checks++;
    if (wq.size() < 2 || wq[0] !== 32'h80008000 || wq[1] !== 32'h7FFF7FFF) begin
      errors++;
      $display("FAIL b2b_words got %h %h required 80008000 7fff7fff", wq.size() > 0 ? wq[0] : '0, wq.size() > 1 ? wq[1] : '0);
    end
  endtask
  task automatic test_underflow();
    int p0, u0;
    logic [DW-1:0] d;
    q.delete();
    fifo_update();
    restart();
    p0 = dut_pops;
    u0 = dut_unf;
    wait_k(0, "underflow");
    checks++;
    if (dut_unf != u0 + 1 || dut_pops != p0) begin
      errors++;
      $display("FAIL underflow_count underflows %0d pops %0d required 1 and 0", dut_unf - u0, dut_pops - p0);
    end
    d = DW'($urandom);
    q.push_back(d);
    fifo_update();
    wait_words(2, "underflow");
    checks++;
    if (wq.size() < 2 || wq[0] !== '0 || wq[1] !== {d, d}) begin
      errors++;
      $display("FAIL underflow_words got %h %h required 0 %h", wq.size() > 0 ? wq[0] : '0, wq.size() > 1 ? wq[1] : '0, {d, d});
    end
  endtask
  task automatic test_en_drop();
    int p0, s0;
    logic [DW-1:0] d;
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(DW'($urandom));
    fifo_update();
    restart();
    wait_k(9, "en_drop");
    en = 1'b0;
    step();
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, underflow, fifo_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL en_drop_outputs got %b required 00000", {i2s_bclk, i2s_lrclk, i2s_sdata, underflow, fifo_rd_en});
    end
    p0 = dut_pops;
    s0 = q.size();
    repeat (40) step();
    checks++;
    if (dut_pops != p0 || q.size() != s0) begin
      errors++;
      $display("FAIL en_drop_idle_pops got %0d pops required 0", dut_pops - p0);
    end
    d = q[0];
    reset_mon();
    en = 1'b1;
    wait_k(0, "reenable");
    checks++;
    if (dut_pops != p0 + 1) begin
      errors++;
      $display("FAIL reenable_pop got %0d pops at first fall required 1", dut_pops - p0);
    end
    wait_words(1, "reenable");
    checks++;
    if (wq.size() < 1 || wq[0] !== {d, d}) begin
      errors++;
      $display("FAIL reenable_word got %h required %h", wq.size() ? wq[0] : '0, {d, d});
    end
  endtask
  task automatic test_random();
    logic [DW-1:0] s[11];
    q.delete();
    for (int i = 0; i < 11; i++) begin
      s[i] = DW'($urandom);
      q.push_back(s[i]);
    end
    fifo_update();
    restart();
    wait_words(10, "random");
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {s[i], s[i]}) begin
        errors++;
        $display("FAIL random_word[%0d] got %h required %h", i, wq[i], {s[i], s[i]});
      end
    end
  endtask
  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    mon = 1'b0;
    {prv_bclk, prv_lr, prv_sd, prv_rd, prv_empty} = '0;
    prv_data = '0;
    reset_mon();
    fifo_update();
    test_reset();
    test_pattern();
    test_back_to_back();
    test_underflow();
    test_en_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
